huff_serial_rx: RTL and testbench
=================================

// Module: huff_serial_rx
// PURPOSE
//  Front-end receive stage of huffChip: recovers framed bytes from the raw serial_in line
//  (idle-high, 1 start bit, DATA_BITS data bits LSB-first, 1 stop bit).
//  Delivers each byte to the downstream Huffman decoder over a valid/ready handshake.
//  Reports framing and overrun faults as single-cycle pulses.
// PARAMETERS
//  CLKS_PER_BIT  4  clk cycles per serial bit; integer >= 2
//  DATA_BITS     8  data bits per frame; 1..8 (byte_data upper bits zero-filled)
// PORTS
//  clk            in   1  system clock, rising edge
//  n_rst          in   1  asynchronous active-low reset
//  serial_in      in   1  raw serial line, idle high, asynchronous to clk
//  byte_ready     in   1  downstream decoder accepts byte_data this cycle
//  byte_data      out  8  received byte, stable while byte_valid=1
//  byte_valid     out  1  byte_data holds an unconsumed byte
//  framing_error  out  1  1-cycle pulse: stop bit sampled low (or parity bad, see CONFIGURATION)
//  overrun_error  out  1  1-cycle pulse: completed byte dropped, output register full
// BEHAVIOUR
//  Reset: byte_data=0, byte_valid=0, framing_error=0, overrun_error=0, FSM=IDLE,
//   both synchroniser flops=1, bit/clk counters=0, shift register=0.
//  Input: serial_in passes a 2-flop synchroniser (rx_s); all FSM decisions use rx_s.
//  FSM states and transitions:
//   IDLE   : rx_s=1 -> stay; rx_s=0 -> START, clk counter cleared.
//   START  : wait CLKS_PER_BIT/2 cycles (integer division) to mid-bit; rx_s=0 -> DATA,
//            rx_s=1 -> IDLE (glitch rejected, no error).
//   DATA   : sample rx_s every CLKS_PER_BIT cycles; shift in LSB-first; after DATA_BITS
//            samples -> PARITY if PARITY_CHECK_EN defined, else STOP.
//   PARITY : sample 1 bit after CLKS_PER_BIT cycles -> STOP.
//   STOP   : sample after CLKS_PER_BIT cycles. rx_s=1 and parity good -> deliver, IDLE.
//            rx_s=0 -> framing_error pulse, byte discarded, WAIT_IDLE.
//            rx_s=1, parity bad -> framing_error pulse, byte discarded, IDLE.
//   WAIT_IDLE: stay until rx_s=1 -> IDLE (no false start from a held-low line).
//  Deliver: on the clock after the stop-bit sample, byte_data<=byte, byte_valid<=1,
//   if register is empty or being consumed the same cycle (byte_valid&byte_ready).
//   Otherwise: old byte kept, new byte dropped, overrun_error pulses 1 cycle.
//  Handshake: transfer on byte_valid&byte_ready; byte_valid falls next cycle unless
//   refilled that same cycle. byte_data never changes while byte_valid=1 and ready=0.
//  Latency: serial_in falling edge to byte_valid =
//   2 + CLKS_PER_BIT/2 + (DATA_BITS+1[+1 parity])*CLKS_PER_BIT + 1 cycles.
//  Counters: clk counter width $clog2(CLKS_PER_BIT), wraps to 0 at each sample point;
//   bit counter width $clog2(DATA_BITS+1).
//  Errors never block reception; next frame starts normally.
//  Reset mid-frame: partial byte discarded, no error pulse, FSM=IDLE immediately.
// CONFIGURATION
//  PARITY_CHECK_EN defined: frame carries even-parity bit after data; mismatch -> frame
//   discarded, framing_error pulses at stop-bit sample time, no delivery.
//  PARITY_CHECK_EN undefined: no parity bit; stop bit follows last data bit; no parity
//   logic synthesised.
// TESTING (CLKS_PER_BIT=4, DATA_BITS=8, parity off unless noted)
//  1 Send frame 0xA5, byte_ready=1 -> byte_valid 1 cycle, byte_data=8'hA5, no error pulse.
//  2 Send 0x3C with stop bit=0 -> framing_error 1 cycle, byte_valid stays 0; line to 1,
//    send 0x81 -> byte_data=8'h81.
//  3 Low glitch of 1 cycle on idle line -> no byte_valid, no error; FSM back to IDLE.
//  4 byte_ready=0, send 0x11 then 0x22 -> byte_data=8'h11 held, overrun_error pulses
//    at second stop; raise ready -> 0x11 consumed, valid falls.
//  5 Two back-to-back frames 0x00,0xFF with byte_ready=1 -> two transfers, in order.
//  6 n_rst low during 4th data bit, release, send 0x5A -> only 0x5A delivered;
//    PARITY_CHECK_EN build: 0x5A with parity=1 -> framing_error, no byte_valid.

Source files
------------

// File: rtl/huff_serial_rx.sv
// Serial receive front-end for huffChip: synchronises serial_in, deframes bytes and hands them downstream.
// Optional even-parity checking is built when PARITY_CHECK_EN is defined.
module huff_serial_rx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_BITS    = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       serial_in,
   input  logic       byte_ready,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       framing_error,
   output logic       overrun_error
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   rx_state_t              state, state_next;
   logic                   rx_meta, rx_s;
   logic [CNT_W-1:0]       clk_cnt, clk_cnt_next;
   logic [BIT_W-1:0]       bit_cnt, bit_cnt_next;
   logic [DATA_BITS-1:0]   shift_reg, shift_next;
   logic                   frame_done, frame_done_next;
   logic                   frame_err_next;
   logic                   parity_bad;
   logic                   tick;

`ifdef PARITY_CHECK_EN
   logic parity_bit, parity_next;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) parity_bit <= 1'b0;
      else        parity_bit <= parity_next;
   end

   // Even parity: data bits plus parity bit must contain an even number of ones.
   assign parity_bad = (^shift_reg) ^ parity_bit;
`else
   assign parity_bad = 1'b0;
`endif

   assign tick = (clk_cnt == BIT_LAST);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         frame_done <= 1'b0;
      end else begin
         rx_meta    <= serial_in;
         rx_s       <= rx_meta;
         state      <= state_next;
         clk_cnt    <= clk_cnt_next;
         bit_cnt    <= bit_cnt_next;
         shift_reg  <= shift_next;
         frame_done <= frame_done_next;
      end
   end

   always_comb begin
      state_next      = state;
      clk_cnt_next    = clk_cnt;
      bit_cnt_next    = bit_cnt;
      shift_next      = shift_reg;
      frame_done_next = 1'b0;
      frame_err_next  = 1'b0;
`ifdef PARITY_CHECK_EN
      parity_next     = parity_bit;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_next   = START;
               clk_cnt_next = '0;
            end
         end
         // Re-check the line at mid start bit so short low glitches are ignored.
         START: begin
            if (clk_cnt == HALF_LAST) begin
               clk_cnt_next = '0;
               bit_cnt_next = '0;
               state_next   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_next = clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (tick) begin
               clk_cnt_next = '0;
               shift_next   = DATA_BITS'({rx_s, shift_reg} >> 1);
               if (bit_cnt == DATA_LAST) begin
                  bit_cnt_next = '0;
`ifdef PARITY_CHECK_EN
                  state_next   = PARITY;
`else
                  state_next   = STOP;
`endif
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end else begin
               clk_cnt_next = clk_cnt + 1'b1;
            end
         end
`ifdef PARITY_CHECK_EN
         PARITY: begin
            if (tick) begin
               clk_cnt_next = '0;
               parity_next  = rx_s;
               state_next   = STOP;
            end else begin
               clk_cnt_next = clk_cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               clk_cnt_next = '0;
               if (!rx_s) begin
                  frame_err_next = 1'b1;
                  state_next     = WAIT_IDLE;
               end else if (parity_bad) begin
                  frame_err_next = 1'b1;
                  state_next     = IDLE;
               end else begin
                  frame_done_next = 1'b1;
                  state_next      = IDLE;
               end
            end else begin
               clk_cnt_next = clk_cnt + 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (rx_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A finished byte loads only if the output register is free or draining this cycle.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         byte_data     <= '0;
         byte_valid    <= 1'b0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         framing_error <= frame_err_next;
         overrun_error <= 1'b0;
         if (frame_done) begin
            if (!byte_valid || byte_ready) begin
               byte_data  <= 8'(shift_reg);
               byte_valid <= 1'b1;
            end else begin
               overrun_error <= 1'b1;
            end
         end else if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_huff_serial_rx.sv
// Self-checking bench for huff_serial_rx: scoreboarded frames, error pulses, reset and latency.
module tb_huff_serial_rx;

   localparam int CPB = 4;
   localparam int DB  = 8;
`ifdef PARITY_CHECK_EN
   localparam int LATENCY = 2 + CPB / 2 + (DB + 2) * CPB + 1;
`else
   localparam int LATENCY = 2 + CPB / 2 + (DB + 1) * CPB + 1;
`endif

   logic       tb_clk = 1'b0;
   logic       n_rst;
   logic       serial_in;
   logic       byte_ready;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       framing_error;
   logic       overrun_error;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         xfer_cnt = 0;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         fall_cyc = 0;
   int         rise_cyc = 0;
   int         spurious = 0;
   int         xfer_base, fe_base, ov_base;
   logic [7:0] exp_q[$];
   logic       hold_prev = 1'b0;
   logic       prev_valid = 1'b0;
   logic [7:0] prev_data = 8'h00;

   huff_serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
      .clk           (tb_clk),
      .n_rst         (n_rst),
      .serial_in     (serial_in),
      .byte_ready    (byte_ready),
      .byte_data     (byte_data),
      .byte_valid    (byte_valid),
      .framing_error (framing_error),
      .overrun_error (overrun_error)
   );

   always #5 tb_clk = ~tb_clk;

   always @(posedge tb_clk) cyc <= cyc + 1;

   task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Output monitor: scoreboard pops, pulse counting and hold-while-stalled checking.
   always @(negedge tb_clk) begin
      if (!n_rst) begin
         hold_prev  = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (hold_prev) check_output("hold", {23'd0, byte_valid, byte_data}, {23'd0, 1'b1, prev_data});
         if (byte_valid && !prev_valid) rise_cyc = cyc;
         if (byte_valid && byte_ready) begin
            xfer_cnt++;
            if (exp_q.size() > 0) check_output("sb_data", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
            else spurious++;
         end
         if (framing_error) fe_cnt++;
         if (overrun_error) ov_cnt++;
         hold_prev  = byte_valid && !byte_ready;
         prev_data  = byte_data;
         prev_valid = byte_valid;
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge tb_clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      serial_in = b;
      idle_cycles(CPB);
   endtask

   // Sends one frame; bad_par flips the parity bit in parity builds.
   task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit, input logic bad_par);
      fall_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) drive_bit(data[i]);
`ifdef PARITY_CHECK_EN
      drive_bit((^data) ^ bad_par);
`endif
      drive_bit(stop_bit);
      if (stop_bit) serial_in = 1'b1;
   endtask

   task automatic mark;
      xfer_base = xfer_cnt;
      fe_base   = fe_cnt;
      ov_base   = ov_cnt;
   endtask

   task automatic check_counts(input string tag, input int xfers, input int fes, input int ovs);
      check_output({tag, "_xfers"}, 32'(xfer_cnt - xfer_base), 32'(xfers));
      check_output({tag, "_framing"}, 32'(fe_cnt - fe_base), 32'(fes));
      check_output({tag, "_overrun"}, 32'(ov_cnt - ov_base), 32'(ovs));
   endtask

   initial begin
      n_rst      = 1'b0;
      serial_in  = 1'b1;
      byte_ready = 1'b0;
      idle_cycles(3);
      check_output("rst_valid", {31'd0, byte_valid}, 32'd0);
      check_output("rst_data", {24'd0, byte_data}, 32'd0);
      check_output("rst_framing", {31'd0, framing_error}, 32'd0);
      check_output("rst_overrun", {31'd0, overrun_error}, 32'd0);
      n_rst = 1'b1;
      idle_cycles(4);

      // Single frame with ready held high, including latency.
      $display("[TB] single frame 0xA5");
      byte_ready = 1'b1;
      mark();
      exp_q.push_back(8'hA5);
      apply_stimulus(8'hA5, 1'b1, 1'b0);
      idle_cycles(8);
      check_output("latency", 32'(rise_cyc - fall_cyc - 1), 32'(LATENCY));
      check_output("valid_low_after", {31'd0, byte_valid}, 32'd0);
      check_counts("t1", 1, 0, 0);

      // Stop bit low, line held low a while, then a good frame.
      $display("[TB] framing error then 0x81");
      mark();
      apply_stimulus(8'h3C, 1'b0, 1'b0);
      idle_cycles(20);
      serial_in = 1'b1;
      idle_cycles(6);
      check_counts("t2a", 0, 1, 0);
      mark();
      exp_q.push_back(8'h81);
      apply_stimulus(8'h81, 1'b1, 1'b0);
      idle_cycles(8);
      check_counts("t2b", 1, 0, 0);

      // One-cycle low glitch, then a normal frame right after.
      $display("[TB] glitch rejection");
      mark();
      serial_in = 1'b0;
      idle_cycles(1);
      serial_in = 1'b1;
      idle_cycles(12);
      check_counts("t3a", 0, 0, 0);
      exp_q.push_back(8'hC3);
      apply_stimulus(8'hC3, 1'b1, 1'b0);
      idle_cycles(8);
      check_counts("t3b", 1, 0, 0);

      // Stalled output: second byte overruns, first byte held.
      $display("[TB] overrun with ready low");
      byte_ready = 1'b0;
      mark();
      exp_q.push_back(8'h11);
      apply_stimulus(8'h11, 1'b1, 1'b0);
      apply_stimulus(8'h22, 1'b1, 1'b0);
      idle_cycles(8);
      check_output("ovr_valid", {31'd0, byte_valid}, 32'd1);
      check_output("ovr_data", {24'd0, byte_data}, 32'h11);
      check_counts("t4a", 0, 0, 1);
      byte_ready = 1'b1;
      idle_cycles(3);
      check_output("ovr_drained", {31'd0, byte_valid}, 32'd0);
      check_counts("t4b", 1, 0, 1);

      // Back-to-back frames.
      $display("[TB] back-to-back 0x00, 0xFF");
      mark();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      apply_stimulus(8'h00, 1'b1, 1'b0);
      apply_stimulus(8'hFF, 1'b1, 1'b0);
      idle_cycles(8);
      check_counts("t5", 2, 0, 0);

      // Reset during the fourth data bit.
      $display("[TB] reset mid-frame");
      mark();
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      serial_in = 1'b0;
      idle_cycles(2);
      n_rst     = 1'b0;
      serial_in = 1'b1;
      idle_cycles(3);
      check_output("midrst_valid", {31'd0, byte_valid}, 32'd0);
      check_output("midrst_framing", {31'd0, framing_error}, 32'd0);
      n_rst = 1'b1;
      idle_cycles(4);
      exp_q.push_back(8'h5A);
      apply_stimulus(8'h5A, 1'b1, 1'b0);
      idle_cycles(8);
      check_counts("t6", 1, 0, 0);

`ifdef PARITY_CHECK_EN
      $display("[TB] bad parity on 0x5A");
      mark();
      apply_stimulus(8'h5A, 1'b1, 1'b1);
      idle_cycles(8);
      check_counts("t6p", 0, 1, 0);
`endif

      check_output("sb_leftover", 32'(exp_q.size()), 32'd0);
      check_output("sb_spurious", 32'(spurious), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
